// File: rtl/main_memory_pkg.sv
// Shared constants and types for the main memory responder and the L2 cache that talks to it.
// The read-only build (MAIN_MEMORY_WRITE_EN undefined) serves the fixed pattern from rom_word().
package main_memory_pkg;

  localparam int MEM_DATA_WIDTH  = 32;
  localparam int MEM_ADDR_WIDTH  = 11;
  localparam int MEM_BLOCK_SIZE  = 32;
  localparam int MEM_LATENCY_DEF = 4;

  localparam int WORDS_PER_BLOCK = MEM_BLOCK_SIZE / (MEM_DATA_WIDTH / 8);
  localparam int OFFSET_WIDTH    = $clog2(MEM_BLOCK_SIZE);
  localparam int WORD_ADDR_WIDTH = MEM_ADDR_WIDTH - 2;
  localparam int BLOCK_WIDTH     = MEM_DATA_WIDTH * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    GAP
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  // Preloaded contents of the read-only store: a tag in the upper half, the word index below it.
  function automatic logic [31:0] rom_word(input int unsigned word_index);
    return 32'hC0DE_0000 | (word_index & 32'h0000_FFFF);
  endfunction

endpackage

// File: rtl/main_memory_array.sv
// Word storage with a combinational block-wide read port and, when MAIN_MEMORY_WRITE_EN is
// defined, one synchronous word write port. Without the macro the contents are fixed (rom_word).
module main_memory_array
  import main_memory_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int WADDR_WIDTH = WORD_ADDR_WIDTH,
  parameter int BLK_WORDS   = WORDS_PER_BLOCK
) (
`ifdef MAIN_MEMORY_WRITE_EN
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [WADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
`endif
  input  logic [WADDR_WIDTH-1:0]          rd_base,
  output logic [DATA_WIDTH*BLK_WORDS-1:0] rd_block
);

`ifdef MAIN_MEMORY_WRITE_EN
  logic [DATA_WIDTH-1:0] mem [2**WADDR_WIDTH];

  // NOTE: the storage array is deliberately not reset; clearing every word would turn the
  // RAM into a wide register file, and the cache never relies on initial contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_block = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      rd_block[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_base + WADDR_WIDTH'(i)];
    end
  end
`else
  always_comb begin
    rd_block = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      rd_block[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rom_word(32'(rd_base) + 32'(i)));
    end
  end
`endif

endmodule

// File: rtl/main_memory.sv
// Fixed-latency backing store behind the L2: block reads, word writes, one-cycle mem_ready pulse.
// Define MAIN_MEMORY_WRITE_EN to let writes update storage; otherwise it behaves as a ROM.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int BLOCK_SIZE  = MEM_BLOCK_SIZE,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [ADDR_WIDTH-1:0]                           mem_addr,
  input  logic [DATA_WIDTH-1:0]                           mem_data_in,
  input  logic                                            mem_read,
  input  logic                                            mem_write,
  output logic [DATA_WIDTH*BLOCK_SIZE/(DATA_WIDTH/8)-1:0] mem_data_block,
  output logic                                            mem_ready
);

  localparam int BLK_WORDS = BLOCK_SIZE / (DATA_WIDTH / 8);
  localparam int BLK_W     = DATA_WIDTH * BLK_WORDS;
  localparam int WADDR_W   = ADDR_WIDTH - 2;
  localparam int WSEL_W    = $clog2(BLK_WORDS);
  localparam int CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e                state;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt;

  op_e                   cur_op;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  enter_resp;
  logic [WADDR_W-1:0]    rd_base;
  logic [BLK_W-1:0]      rd_block;

  // In IDLE the live request is used directly so a single-cycle latency can respond at once;
  // afterwards the latched request is used and the inputs are ignored.
  // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
  always_comb begin
    cur_op     = op_q;
    cur_addr   = addr_q;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        cur_op     = mem_write ? OP_WRITE : OP_READ;
        cur_addr   = mem_addr;
        enter_resp = (MEM_LATENCY == 1) && (mem_read || mem_write);
      end
      BUSY:    enter_resp = (cnt == CNT_W'(1));
      default: ;
    endcase
  end

  assign rd_base = {cur_addr[ADDR_WIDTH-1:WSEL_W+2], WSEL_W'(0)};

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= OP_READ;
      addr_q         <= '0;
      cnt            <= '0;
      mem_ready      <= 1'b0;
      mem_data_block <= '0;
    end else begin
      mem_ready <= enter_resp;
      if (enter_resp && cur_op == OP_READ) begin
        mem_data_block <= rd_block;
      end
      unique case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            op_q   <= cur_op;
            addr_q <= mem_addr;
            cnt    <= CNT_W'(MEM_LATENCY - 1);
            state  <= (MEM_LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (enter_resp) begin
            state <= RESP;
          end
        end
        RESP:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAIN_MEMORY_WRITE_EN
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  unused_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (state == IDLE && (mem_read || mem_write)) begin
      data_q <= mem_data_in;
    end
  end

  assign cur_data    = (state == IDLE) ? mem_data_in : data_q;
  assign unused_addr = ^cur_addr[1:0];

  main_memory_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WADDR_WIDTH (WADDR_W),
    .BLK_WORDS   (BLK_WORDS)
  ) u_array (
    .clk      (clk),
    .wr_en    (enter_resp && cur_op == OP_WRITE),
    .wr_addr  (cur_addr[ADDR_WIDTH-1:2]),
    .wr_data  (cur_data),
    .rd_base  (rd_base),
    .rd_block (rd_block)
  );
`else
  logic unused_inputs;

  // Writes are acknowledged with normal timing but carry no data path in the ROM build.
  assign unused_inputs = ^{cur_addr[WSEL_W+1:0], mem_data_in};

  main_memory_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WADDR_WIDTH (WADDR_W),
    .BLK_WORDS   (BLK_WORDS)
  ) u_array (
    .rd_base  (rd_base),
    .rd_block (rd_block)
  );
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: expected responses are queued when a request is driven and
// popped when mem_ready is seen. Builds with or without MAIN_MEMORY_WRITE_EN.
module tb_main_memory;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [10:0]  addr, addr1;
  logic [31:0]  din, din1;
  logic         rd, wr, rd1, wr1;
  logic [255:0] blk, blk1;
  logic         rdy, rdy1;

  always #5 clk = ~clk;

  main_memory #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_data_in(din), .mem_read(rd),
    .mem_write(wr), .mem_data_block(blk), .mem_ready(rdy)
  );

  main_memory #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr1), .mem_data_in(din1), .mem_read(rd1),
    .mem_write(wr1), .mem_data_block(blk1), .mem_ready(rdy1)
  );

  typedef struct {
    int           lat;
    logic [255:0] blk;
    logic [7:0]   known;
  } exp_t;

  exp_t         sb[$];
  logic [31:0]  mm [512];
  bit           mk [512];
  logic [255:0] last_blk;
  logic [7:0]   last_known;
  int           n_checks = 0;
  int           n_errors = 0;
  int           pulses1  = 0;

  always @(negedge clk) if (rdy1 === 1'b1) pulses1++;

  function automatic logic [31:0] rom_pat(input int idx);
    logic [31:0] v;
    v = 32'hC0DE_0000;
    v[15:0] = idx[15:0];
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d;
  endtask

  task automatic push_read(input logic [10:0] a, input int lat);
    exp_t e;
    int   base;
    base    = int'(a[10:2]) & ~7;
    e.lat   = lat;
    e.blk   = '0;
    e.known = '0;
    for (int i = 0; i < 8; i++) begin
      e.blk[i*32 +: 32] = mm[base+i];
      e.known[i]        = mk[base+i];
    end
    sb.push_back(e);
    last_blk   = e.blk;
    last_known = e.known;
  endtask

  task automatic push_write(input logic [10:0] a, input logic [31:0] d, input int lat);
    exp_t e;
    e.lat   = lat;
    e.blk   = last_blk;
    e.known = last_known;
    sb.push_back(e);
`ifdef MAIN_MEMORY_WRITE_EN
    mm[int'(a[10:2])] = d;
    mk[int'(a[10:2])] = 1'b1;
`else
    if (a === 11'h7FF && d === 32'h0) last_known = last_known;
`endif
  endtask

  // Cycle k is the one ending at (acceptance edge + k); outputs are sampled mid-cycle.
  task automatic collect(input int window, input int release_k, input int swap_k,
                         input logic [10:0] swap_addr);
    exp_t e;
    @(posedge clk);
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_ready_cycle", 256'(k), 256'd0);
        end else begin
          e = sb.pop_front();
          check("ready_latency", 256'(k), 256'(e.lat));
          for (int i = 0; i < 8; i++)
            if (e.known[i])
              check($sformatf("block_word%0d", i), 256'(blk[i*32 +: 32]), 256'(e.blk[i*32 +: 32]));
        end
      end else if (rdy !== 1'b0) begin
        check("ready_defined", 256'(rdy), 256'd0);
      end
      if (k == swap_k) addr = swap_addr;
      if (k == release_k) begin
        rd = 1'b0;
        wr = 1'b0;
      end
    end
    check("responses_outstanding", 256'(sb.size()), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          quiet;
    int          p0;
    logic [10:0] ra;

    rst_n = 1'b1;
    rd = 0; wr = 0; addr = '0; din = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; din1 = '0;
    for (int i = 0; i < 512; i++) begin
`ifdef MAIN_MEMORY_WRITE_EN
      mm[i] = 'x;
      mk[i] = 1'b0;
`else
      mm[i] = rom_pat(i);
      mk[i] = 1'b1;
`endif
    end
    last_blk   = '0;
    last_known = '1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 256'(rdy), 256'd0);
    check("reset_block", blk, 256'd0);
    check("reset_ready_l1", 256'(rdy1), 256'd0);
    check("reset_block_l1", blk1, 256'd0);
    rst_n = 1'b1;

    // write then read the block that contains it
    drive(0, 1, 11'h024, 32'hDEADBEEF); push_write(11'h024, 32'hDEADBEEF, L); collect(L+5, L+1, 0, '0);
    drive(1, 0, 11'h03C, 32'h0);        push_read(11'h03C, L);                collect(L+5, L+1, 0, '0);

    // request held through the GAP cycle must not be accepted twice
    drive(1, 0, 11'h100, 32'h0); push_read(11'h100, L); collect(L+8, L+2, 0, '0);

    // single-cycle latency instance, also held through its GAP cycle
    @(negedge clk);
    p0 = pulses1;
    rd1 = 1'b1; addr1 = 11'h03C;
    @(posedge clk);
    @(negedge clk);
    check("lat1_ready_at_t1", 256'(rdy1), 256'd1);
`ifndef MAIN_MEMORY_WRITE_EN
    check("lat1_block_word1", 256'(blk1[63:32]), 256'(rom_pat(9)));
`endif
    @(negedge clk);
    check("lat1_ready_one_cycle", 256'(rdy1), 256'd0);
    @(negedge clk);
    rd1 = 1'b0;
    repeat (6) @(negedge clk);
    check("lat1_pulse_count", 256'(pulses1 - p0), 256'd1);

    // simultaneous read and write: the write wins and the block output is untouched
    drive(1, 1, 11'h040, 32'h12345678); push_write(11'h040, 32'h12345678, L); collect(L+5, L+1, 0, '0);
    drive(1, 0, 11'h040, 32'h0);        push_read(11'h040, L);                collect(L+5, L+1, 0, '0);

    // all-ones write to word 0, then read it back
    drive(0, 1, 11'h000, 32'hFFFFFFFF); push_write(11'h000, 32'hFFFFFFFF, L); collect(L+5, L+1, 0, '0);
    drive(1, 0, 11'h000, 32'h0);        push_read(11'h000, L);                collect(L+5, L+1, 0, '0);

    // reset two cycles after accepting a write aborts it
    drive(0, 1, 11'h080, 32'hA5A5A5A5);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    check("abort_ready", 256'(rdy), 256'd0);
    check("abort_block_cleared", blk, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_blk   = '0;
    last_known = '1;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy !== 1'b0) quiet++;
    end
    check("abort_no_ready", 256'(quiet), 256'd0);
    drive(1, 0, 11'h080, 32'h0); push_read(11'h080, L); collect(L+5, L+1, 0, '0);
    check("abort_write_dropped", 256'(blk[31:0] === 32'hA5A5A5A5), 256'd0);

    // a few reads at arbitrary addresses (offset bits must be ignored)
    for (int n = 0; n < 4; n++) begin
      ra = 11'($urandom_range(2047, 0));
      drive(1, 0, ra, 32'h0); push_read(ra, L); collect(L+5, L+1, 0, '0);
    end

    // read held across two responses; address changed while BUSY is only seen by the second
    drive(1, 0, 11'h1E4, 32'h0);
    push_read(11'h1E4, L);
    push_read(11'h2A0, 2*L+2);
    collect(2*L+8, 2*L+3, 2, 11'h2A0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
